note_judge_ctrl: RTL and testbench



---
 rtl/note_judge_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_note_judge_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_judge_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : note_judge_ctrl
//  Description : Beat-chart note scheduler and lane hit judge. Walks the chart
//                ROM, spawns notes into per-lane flight timers, judges key
//                presses against a hit window and reports miss / recover /
//                done to the game control FSM plus combo and lane occupancy
//                to the display path.
//                Optional feature macro: JUDGE_PERFECT_EN adds PERFECT_WIN
//                and a saturating perfect_cnt output.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_judge_ctrl #(
    parameter int LANES        = 4,
    parameter int ADDR_W       = 8,
    parameter int TICK_DIV     = 50000,
    parameter int TRAVEL       = 32,
    parameter int HIT_WIN      = 4,
    parameter int RECOVER_HITS = 8
`ifdef JUDGE_PERFECT_EN
    ,
    parameter int PERFECT_WIN  = 1
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              map,
    input  logic              chance,
    input  logic [LANES-1:0]  lane_key,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [LANES+7:0]  rom_data,
    output logic              miss,
    output logic              recover,
    output logic              done,
    output logic [7:0]        combo,
    output logic [LANES-1:0]  lane_active,
    output logic              note_hit
`ifdef JUDGE_PERFECT_EN
    ,
    output logic [9:0]        perfect_cnt
`endif
);

    localparam int c_PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_SPAWN = 3'd3,
        ST_RUN   = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_map_q;
    logic [LANES-1:0]     r_key_q;
    logic [c_PRESC_W-1:0] r_presc;
    logic [ADDR_W-1:0]    r_addr;
    logic [LANES-1:0]     r_mask;
    logic [7:0]           r_delta;
    logic [7:0]           r_dcnt;
    logic [7:0]           r_timer [LANES];
    logic [LANES-1:0]     r_active;
    logic [2:0]           r_mq;
    logic [1:0]           r_mcnt;
    logic                 r_miss;
    logic [7:0]           r_combo;
    logic [7:0]           r_streak;
    logic                 r_recover;
    logic                 r_note_hit;

    logic                 w_abort, w_map_rise, w_counting, w_tick, w_miss_start;
    logic [LANES-1:0]     w_press, w_hit, w_exp, w_spawn, w_lmiss;
    logic [7:0]           w_nhit, w_nmiss, w_mq_sum;
    logic [2:0]           w_mq_nxt;
    logic [8:0]           w_combo_sum, w_streak_sum;

    // Dropping map anywhere outside IDLE abandons the chart on the next edge.
    assign w_abort      = (r_state != ST_IDLE) && !map;
    assign w_map_rise   = map && !r_map_q;
    assign w_counting   = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_tick       = w_counting && (r_presc == c_PRESC_W'(TICK_DIV - 1));
    assign w_miss_start = (r_mcnt == 2'd0) && (r_mq != 3'd0);

    // Per-lane judging: hits beat expiry, re-spawn over a live note is a miss.
    always_comb begin
        w_press = lane_key & ~r_key_q;
        w_hit   = '0;
        w_exp   = '0;
        w_spawn = '0;
        w_lmiss = '0;
        w_nhit  = 8'd0;
        w_nmiss = 8'd0;
        for (int i = 0; i < LANES; i++) begin
            w_spawn[i] = (r_state == ST_SPAWN) && r_mask[i];
            w_hit[i]   = w_press[i] && r_active[i] && (r_timer[i] <= 8'(HIT_WIN));
            w_exp[i]   = r_active[i] && w_tick && (r_timer[i] <= 8'd1) && !w_hit[i];
            w_lmiss[i] = w_exp[i] || (w_spawn[i] && r_active[i] && !w_hit[i]);
            w_nhit     = w_nhit  + {7'd0, w_hit[i]};
            w_nmiss    = w_nmiss + {7'd0, w_lmiss[i]};
        end
    end

    // Saturating arithmetic for the miss queue, combo and streak.
    always_comb begin
        w_mq_sum     = {5'd0, r_mq} + w_nmiss - {7'd0, w_miss_start};
        w_mq_nxt     = (w_mq_sum > 8'd7) ? 3'd7 : w_mq_sum[2:0];
        w_combo_sum  = {1'b0, r_combo}  + {1'b0, w_nhit};
        w_streak_sum = {1'b0, r_streak} + {1'b0, w_nhit};
        if (w_combo_sum[8])  w_combo_sum  = 9'd255;
        if (w_streak_sum[8]) w_streak_sum = 9'd255;
    end

    // Chart-walk state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Chart-walk next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_map_rise) w_state_nxt = ST_FETCH;
            ST_FETCH: w_state_nxt = ST_LATCH;
            ST_LATCH: w_state_nxt = (rom_data == '0) ? ST_DRAIN : ST_SPAWN;
            ST_SPAWN: w_state_nxt = ST_RUN;
            ST_RUN:   if ((r_dcnt == 8'd0) || (w_tick && (r_dcnt == 8'd1)))
                          w_state_nxt = ST_FETCH;
            ST_DRAIN: if ((r_active == '0) && (r_mq == 3'd0) && !r_miss)
                          w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_abort) w_state_nxt = ST_IDLE;
    end

    // Input history, tick prescaler, ROM address and delta countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_map_q <= 1'b0;
            r_key_q <= '0;
        end else begin
            r_map_q <= map;
            r_key_q <= lane_key;
        end
        if (reset || w_abort) begin
            r_presc <= '0;
            r_addr  <= '0;
            r_mask  <= '0;
            r_delta <= 8'd0;
            r_dcnt  <= 8'd0;
        end else begin
            if (w_tick)          r_presc <= '0;
            else if (w_counting) r_presc <= r_presc + c_PRESC_W'(1);
            if (r_state == ST_IDLE && w_map_rise) r_addr <= '0;
            if (r_state == ST_LATCH) begin
                r_mask  <= rom_data[LANES+7:8];
                r_delta <= rom_data[7:0];
            end
            if (r_state == ST_SPAWN) begin
                r_dcnt <= r_delta;
                r_addr <= r_addr + ADDR_W'(1);
            end else if (r_state == ST_RUN && w_tick && r_dcnt != 8'd0) begin
                r_dcnt <= r_dcnt - 8'd1;
            end
        end
    end

    // Lane flight timers and occupancy.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (reset || w_abort) begin
                r_timer[i]  <= 8'd0;
                r_active[i] <= 1'b0;
            end else if (w_spawn[i]) begin
                r_timer[i]  <= 8'(TRAVEL);
                r_active[i] <= 1'b1;
            end else if (w_hit[i] || w_exp[i]) begin
                r_timer[i]  <= 8'd0;
                r_active[i] <= 1'b0;
            end else if (w_tick && r_active[i]) begin
                r_timer[i]  <= r_timer[i] - 8'd1;
            end
        end
    end

    // Scoring: miss pulse player (2 high / 2 low), combo, streak and recover.
    always_ff @(posedge clk) begin
        if (reset || w_abort) begin
            r_mq       <= 3'd0;
            r_mcnt     <= 2'd0;
            r_miss     <= 1'b0;
            r_combo    <= 8'd0;
            r_streak   <= 8'd0;
            r_recover  <= 1'b0;
            r_note_hit <= 1'b0;
        end else begin
            r_note_hit <= (w_nhit != 8'd0);
            r_mq       <= w_mq_nxt;
            if (w_miss_start) begin
                r_miss <= 1'b1;
                r_mcnt <= 2'd3;
            end else if (r_mcnt != 2'd0) begin
                r_miss <= (r_mcnt == 2'd3);
                r_mcnt <= r_mcnt - 2'd1;
            end
            if (w_nmiss != 8'd0) begin
                r_combo  <= 8'd0;
                r_streak <= 8'd0;
            end else if (w_nhit != 8'd0) begin
                r_combo  <= w_combo_sum[7:0];
                r_streak <= w_streak_sum[7:0];
            end
            // A consumed recover (chance closes) spends the streak.
            if (!chance) begin
                r_recover <= 1'b0;
                if (r_recover) r_streak <= 8'd0;
            end else if (r_streak >= 8'(RECOVER_HITS)) begin
                r_recover <= 1'b1;
            end
        end
    end

`ifdef JUDGE_PERFECT_EN
    logic [7:0]  w_nperf;
    logic [10:0] w_perf_sum;
    logic [9:0]  r_perfect;

    // Count hits landing inside the tighter perfect window.
    always_comb begin
        w_nperf = 8'd0;
        for (int i = 0; i < LANES; i++)
            w_nperf = w_nperf + {7'd0, (w_hit[i] && (r_timer[i] <= 8'(PERFECT_WIN)))};
        w_perf_sum = {1'b0, r_perfect} + {3'd0, w_nperf};
    end

    // Saturating perfect counter; abort is the only way back to IDLE.
    always_ff @(posedge clk) begin
        if (reset || w_abort)       r_perfect <= 10'd0;
        else if (w_perf_sum[10])    r_perfect <= 10'd1023;
        else                        r_perfect <= w_perf_sum[9:0];
    end

    assign perfect_cnt = r_perfect;
`endif

    assign rom_addr    = r_addr;
    assign miss        = r_miss;
    assign recover     = r_recover;
    assign done        = (r_state == ST_DONE);
    assign combo       = r_combo;
    assign lane_active = r_active;
    assign note_hit    = r_note_hit;

endmodule
`default_nettype wire

// File: tb/tb_note_judge_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_note_judge_ctrl
//  Description : Scoreboard bench for note_judge_ctrl. Directed charts push
//                expected events (hit, miss pulse width, recover, done) into a
//                queue; a negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_note_judge_ctrl;

    localparam int c_EV_HIT  = 1;
    localparam int c_EV_MISS = 2;
    localparam int c_EV_REC  = 3;
    localparam int c_EV_DONE = 4;

    typedef struct packed {
        logic [3:0]  kind;
        logic [15:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset, map, chance;
    logic [3:0]  lane_key;
    logic [7:0]  rom_addr;
    logic [11:0] rom_data;
    logic        miss, recover, done, note_hit;
    logic [7:0]  combo;
    logic [3:0]  lane_active;

    logic [11:0] rom [256];
    ev_t         exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    // Monitor state
    logic        m_prev = 1'b0, r_prev = 1'b0, d_prev = 1'b0;
    int          mwidth = 0, lowcnt = 0;
    bit          have_fall = 1'b0;

    always #5 clk = ~clk;

    note_judge_ctrl #(
        .LANES(4), .ADDR_W(8), .TICK_DIV(2), .TRAVEL(8),
        .HIT_WIN(2), .RECOVER_HITS(3)
    ) dut (
        .clk(clk), .reset(reset), .map(map), .chance(chance),
        .lane_key(lane_key), .rom_addr(rom_addr), .rom_data(rom_data),
        .miss(miss), .recover(recover), .done(done), .combo(combo),
        .lane_active(lane_active), .note_hit(note_hit)
    );

    // Synchronous chart ROM: data valid one cycle after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic expect_ev(input int k, input int v);
        ev_t e;
        e.kind = 4'(k);
        e.val  = 16'(v);
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input int k, input int v, input string nm);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: got unexpected event value %0d, expected no event", nm, v);
        end else begin
            e = exp_q.pop_front();
            if (int'(e.kind) != k || int'(e.val) != v) begin
                n_err++;
                $display("FAIL %s: got kind %0d value %0d, expected kind %0d value %0d",
                         nm, k, v, e.kind, e.val);
            end
        end
    endtask

    // Event monitor, fixed order per cycle: hit, miss, recover, done.
    always @(negedge clk) begin
        if (note_hit) got_ev(c_EV_HIT, int'(combo), "hit_ev");
        if (miss) begin
            if (!m_prev) begin
                if (have_fall) chk("miss_gap_ge2", int'(lowcnt >= 2), 1);
                mwidth = 0;
            end
            mwidth++;
        end else if (m_prev) begin
            got_ev(c_EV_MISS, mwidth, "miss_width");
            have_fall = 1'b1;
            lowcnt    = 0;
        end
        if (!miss) lowcnt++;
        if (recover && !r_prev) got_ev(c_EV_REC, int'(combo), "recover_ev");
        if (done && !d_prev)    got_ev(c_EV_DONE, int'(combo), "done_ev");
        if (reset || !map) have_fall = 1'b0;
        m_prev = miss;
        r_prev = recover;
        d_prev = done;
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int t = 0;
        while (!done && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk(nm, int'(done), 1);
    endtask

    // Press a lane key dly cycles after its note is first seen in flight.
    // dly=12 lands on timer==2 and dly=6 on timer==5 for either tick phase.
    task automatic press_lane(input int ln, input int dly);
        int t = 0;
        while (!lane_active[ln] && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (dly) @(negedge clk);
        lane_key[ln] = 1'b1;
        repeat (2) @(negedge clk);
        lane_key[ln] = 1'b0;
    endtask

    task automatic end_run();
        map = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int w, t, highs;
        reset = 1'b1; map = 1'b0; chance = 1'b0; lane_key = 4'h0;
        clear_rom();
        repeat (3) @(negedge clk);
        chk("rst_miss", int'(miss), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_combo", int'(combo), 0);
        chk("rst_lanes", int'(lane_active), 0);
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_recover", int'(recover), 0);
        reset = 1'b0;
        @(negedge clk);

        // T1: single note, no key -> one 2-cycle miss, then done
        rom[0] = 12'h104;
        expect_ev(c_EV_MISS, 2);
        expect_ev(c_EV_DONE, 0);
        map = 1'b1;
        w = 0; t = 0;
        while (!lane_active[0] && t < 100) begin @(negedge clk); t++; end
        while (lane_active[0] && t < 200) begin w++; @(negedge clk); t++; end
        // 8 ticks of 2 cycles; the first tick phase may fall 1 cycle early
        chk("t1_flight_15to16", int'(w >= 15 && w <= 16), 1);
        wait_done("t1_done", 200);
        @(negedge clk);
        chk("t1_queue_empty", exp_q.size(), 0);
        end_run();

        // T2a: press at timer==2 -> hit, combo 1, done without miss
        expect_ev(c_EV_HIT, 1);
        expect_ev(c_EV_DONE, 1);
        map = 1'b1;
        press_lane(0, 12);
        wait_done("t2a_done", 200);
        @(negedge clk);
        chk("t2a_queue_empty", exp_q.size(), 0);
        end_run();

        // T2b: press at timer==5 -> ignored, note misses
        expect_ev(c_EV_MISS, 2);
        expect_ev(c_EV_DONE, 0);
        map = 1'b1;
        press_lane(0, 6);
        wait_done("t2b_done", 200);
        @(negedge clk);
        chk("t2b_queue_empty", exp_q.size(), 0);
        end_run();

        // T3: four simultaneous expiries -> four separate pulses
        clear_rom();
        rom[0] = 12'hF0A;
        for (int i = 0; i < 4; i++) expect_ev(c_EV_MISS, 2);
        expect_ev(c_EV_DONE, 0);
        map = 1'b1;
        wait_done("t3_done", 400);
        @(negedge clk);
        chk("t3_queue_empty", exp_q.size(), 0);
        end_run();

        // T4: three hits with chance open -> recover, then chance closes
        clear_rom();
        rom[0] = 12'h103; rom[1] = 12'h203; rom[2] = 12'h402;
        chance = 1'b1;
        expect_ev(c_EV_HIT, 1);
        expect_ev(c_EV_HIT, 2);
        expect_ev(c_EV_HIT, 3);
        expect_ev(c_EV_REC, 3);
        expect_ev(c_EV_DONE, 3);
        map = 1'b1;
        fork
            press_lane(0, 12);
            press_lane(1, 12);
            press_lane(2, 12);
        join
        wait_done("t4_done", 400);
        @(negedge clk);
        chk("t4_queue_empty", exp_q.size(), 0);
        chance = 1'b0;
        @(negedge clk);
        chk("t4_recover_drop", int'(recover), 0);
        chance = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4_streak_cleared", int'(recover), 0);
        chance = 1'b0;
        map = 1'b0;
        @(negedge clk);
        chk("t4_abort_combo", int'(combo), 0);
        chk("t4_abort_done", int'(done), 0);
        repeat (2) @(negedge clk);

        // T5: abort mid-RUN with lane1 still in flight
        clear_rom();
        rom[0] = 12'h101; rom[1] = 12'h20C;
        expect_ev(c_EV_HIT, 1);
        map = 1'b1;
        press_lane(0, 12);
        @(negedge clk);
        chk("t5_lanes_before", int'(lane_active), 2);
        chk("t5_combo_before", int'(combo), 1);
        map = 1'b0;
        @(negedge clk);
        chk("t5_abort_lanes", int'(lane_active), 0);
        chk("t5_abort_combo", int'(combo), 0);
        chk("t5_abort_miss", int'(miss), 0);
        chk("t5_queue_empty", exp_q.size(), 0);
        repeat (2) @(negedge clk);

        // T6: restart from address 0, then reset while miss is high in DRAIN
        clear_rom();
        rom[0] = 12'h301;
        map = 1'b1;
        @(negedge clk);
        chk("t6_restart_addr", int'(rom_addr), 0);
        t = 0;
        while (lane_active != 4'b0011 && t < 50) begin @(negedge clk); t++; end
        chk("t6_restart_lanes", int'(lane_active), 3);
        t = 0;
        while (!miss && t < 100) begin @(negedge clk); t++; end
        chk("t6_miss_seen", int'(miss), 1);
        expect_ev(c_EV_MISS, 1);
        reset = 1'b1;
        map = 1'b0;
        @(negedge clk);
        chk("t6_rst_miss", int'(miss), 0);
        chk("t6_rst_lanes", int'(lane_active), 0);
        chk("t6_rst_done", int'(done), 0);
        chk("t6_rst_addr", int'(rom_addr), 0);
        reset = 1'b0;
        highs = 0;
        repeat (12) begin
            @(negedge clk);
            if (miss) highs++;
        end
        chk("t6_queue_flushed", highs, 0);
        chk("t6_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
